// File: rtl/settings_pkg.sv
// Shared sizes, FSM state type and window decoding for moving_average_inverse.
package settings_pkg;

  localparam int DATA_SIZE   = 16;
  localparam int WINDOW_SIZE = 6;
  localparam int MAX_WINDOW  = 64;
  localparam int FULL_SIZE   = DATA_SIZE + WINDOW_SIZE;
  localparam int LOG2_W      = $clog2(WINDOW_SIZE + 1);

  typedef logic [WINDOW_SIZE:0] window_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FAULT
  } state_t;

  typedef struct packed {
    logic              legal;
    logic [LOG2_W-1:0] log2;
  } window_info_t;

  // A window is legal only if it is exactly one of the powers of two 1..MAX_WINDOW.
  function automatic window_info_t decode_window(input window_t window);
    window_info_t info;
    info.legal = 1'b0;
    info.log2  = '0;
    for (int i = 0; i <= WINDOW_SIZE; i++) begin
      if (window == (window_t'(1) << i)) begin
        info.legal = 1'b1;
        info.log2  = LOG2_W'(i);
      end
    end
    return info;
  endfunction

endpackage

// File: rtl/sample_history.sv
// MAX_WINDOW-deep shift register of reconstructed samples; tap selects hist[N-1].
module sample_history
  import settings_pkg::*;
(
  input  logic                          clk,
  input  logic                          clear,
  input  logic                          shift,
  input  logic signed [DATA_SIZE-1:0]   din,
  input  logic        [WINDOW_SIZE-1:0] tap,
  output logic signed [DATA_SIZE-1:0]   dout
);

  logic signed [DATA_SIZE-1:0] hist [MAX_WINDOW];

  // NOTE: this storage is deliberately cleared on reset; the decoder relies on an
  // all-zero history, so it cannot be left uninitialised like an ordinary RAM.
  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < MAX_WINDOW; i++) hist[i] <= '0;
    end else if (shift) begin
      hist[0] <= din;
      for (int i = 1; i < MAX_WINDOW; i++) hist[i] <= hist[i-1];
    end
  end

  assign dout = hist[tap];

endmodule

// File: rtl/moving_average_inverse.sv
// Decoder for moving_average window sums: x[n] = S[n] - S[n-1] + x[n-N].
// Build option: define MA_INVERSE_SATURATE_EN to clamp out-of-range results and flag overflow.
module moving_average_inverse
  import settings_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic signed [FULL_SIZE-1:0] input_data,
  input  logic                        input_data_valid,
  input  logic        [WINDOW_SIZE:0] window,
  output logic signed [DATA_SIZE-1:0] output_data,
  output logic                        output_data_valid,
  output logic                        window_error,
  output logic                        overflow
);

  localparam int D_W = FULL_SIZE + 1;
  localparam int R_W = FULL_SIZE + 2;

`ifdef MA_INVERSE_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  localparam logic signed [DATA_SIZE-1:0] DATA_MAX = {1'b0, {(DATA_SIZE-1){1'b1}}};
  localparam logic signed [DATA_SIZE-1:0] DATA_MIN = {1'b1, {(DATA_SIZE-1){1'b0}}};
  localparam logic signed [R_W-1:0]       R_MAX    = R_W'(DATA_MAX);
  localparam logic signed [R_W-1:0]       R_MIN    = R_W'(DATA_MIN);

  state_t       state, next_state;
  window_info_t win_info;
  logic [LOG2_W-1:0] win_log2;
  window_t      win_latched;
  logic         win_changed;
  logic         keep;
  logic         accept;

  logic signed [FULL_SIZE-1:0] s0, s_prev;
  logic                        v0, v1;
  logic signed [D_W-1:0]       d1;
  logic signed [R_W-1:0]       r;
  logic signed [DATA_SIZE-1:0] hist_tap, result;
  logic                        range_hit, ovf, retire;
  logic [WINDOW_SIZE-1:0]      tap;

  assign win_info    = decode_window(window);
  assign win_latched = window_t'(1) << win_log2;
  assign win_changed = (window != win_latched);
  assign tap         = WINDOW_SIZE'(win_latched - 1'b1);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // NOTE: next_state gets a default before the case so no path leaves it unassigned
  // (which would infer a latch).
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (input_data_valid) next_state = win_info.legal ? RUN : FAULT;
      RUN:     if (win_changed)      next_state = FAULT;
      FAULT:   next_state = FAULT;
      default: next_state = FAULT;
    endcase
  end

  // Anything leaving RUN kills the whole pipeline, including samples already in flight.
  always_comb begin
    window_error = (state == FAULT);
    keep         = (next_state == RUN);
    accept       = input_data_valid && keep;
  end

  always_ff @(posedge clk) begin
    if (reset)                        win_log2 <= '0;
    else if (state == IDLE && accept) win_log2 <= win_info.log2;
  end

  // Stage 0: register the accepted window sum.
  always_ff @(posedge clk) begin
    if (reset) begin
      s0 <= '0;
      v0 <= 1'b0;
    end else begin
      v0 <= accept;
      if (accept) s0 <= input_data;
    end
  end

  // Stage 1: first difference of consecutive sums.
  always_ff @(posedge clk) begin
    if (reset) begin
      d1     <= '0;
      s_prev <= '0;
      v1     <= 1'b0;
    end else begin
      v1 <= v0 && keep;
      if (v0 && keep) begin
        d1     <= D_W'(s0) - D_W'(s_prev);
        s_prev <= s0;
      end
    end
  end

  // Stage 2: add back the sample leaving the window, then clamp or wrap.
  always_comb begin
    r         = R_W'(d1) + R_W'(hist_tap);
    range_hit = (r > R_MAX) || (r < R_MIN);
    ovf       = SAT_EN && range_hit;
    result    = r[DATA_SIZE-1:0];
    if (ovf) result = (r > R_MAX) ? DATA_MAX : DATA_MIN;
  end

  assign retire = v1 && keep;

  always_ff @(posedge clk) begin
    if (reset) begin
      output_data       <= '0;
      output_data_valid <= 1'b0;
      overflow          <= 1'b0;
    end else begin
      output_data_valid <= retire;
      overflow          <= retire && ovf;
      if (retire) output_data <= result;
    end
  end

  sample_history u_history (
    .clk   (clk),
    .clear (reset),
    .shift (retire),
    .din   (result),
    .tap   (tap),
    .dout  (hist_tap)
  );

endmodule
